// File: rtl/bus_transfer_sequencer.sv
// Register-transfer sequencer: queues (src, dst) bus-code pairs and plays each out as a
// DRIVE/LATCH pair of one-hot enables. Define BUS_XFER_HOLD_EN to add the 'hold' input.
module bus_transfer_sequencer #(
    parameter int DEPTH = 4,
    parameter int NCODE = 25
) (
    input  logic                     clk,
    input  logic                     clr_n,
`ifdef BUS_XFER_HOLD_EN
    input  logic                     hold,
`endif
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_src,
    input  logic [4:0]               req_dst,
    output logic [NCODE-1:0]         out_en,
    output logic [NCODE-1:0]         in_en,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LATCH
    } state_e;

    logic [4:0]       src_mem [DEPTH];
    logic [4:0]       dst_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [4:0]       src_q, src_d;
    logic [4:0]       dst_q, dst_d;
    logic             err_q, err_d;
    logic [NCODE-1:0] out_en_q, out_en_d;
    logic [NCODE-1:0] in_en_q, in_en_d;

    logic             full, empty, push, pop;
    logic [4:0]       head_src, head_dst;
    logic             head_legal;

    function automatic logic [NCODE-1:0] onehot(input logic [4:0] code);
        return {{(NCODE-1){1'b0}}, 1'b1} << code;
    endfunction

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = req_valid && !full;
    assign head_src   = src_mem[rd_ptr_q];
    assign head_dst   = dst_mem[rd_ptr_q];
    // HI..Zlo sources are fine, but Zhigh, Zlo and C_extended can never be loaded.
    assign head_legal = (int'(head_src) < NCODE) && (head_dst <= 5'd23)
                        && (head_dst != 5'd18) && (head_dst != 5'd19);

    // NOTE: the FIFO storage has no reset; occupancy is tracked by count_q, so stale
    // entries are never observed and the array can map onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr_q] <= req_src;
            dst_mem[wr_ptr_q] <= req_dst;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        err_d    = err_q;
        pop      = 1'b0;
        case (state_q)
            IDLE, LATCH: begin
                state_d = IDLE;
                if (!empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        state_d = DRIVE;
                        src_d   = head_src;
                        dst_d   = head_dst;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
`ifdef BUS_XFER_HOLD_EN
                state_d = hold ? DRIVE : LATCH;
`else
                state_d = LATCH;
`endif
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        // Enables are decoded from next state and registered, so they never glitch.
        out_en_d = (state_d != IDLE)  ? onehot(src_d) : '0;
        in_en_d  = (state_d == LATCH) ? onehot(dst_d) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            err_q    <= 1'b0;
            out_en_q <= '0;
            in_en_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            err_q    <= err_d;
            out_en_q <= out_en_d;
            in_en_q  <= in_en_d;
        end
    end

    assign req_ready = !full;
    assign busy      = (state_q != IDLE) || !empty;
    assign err       = err_q;
    assign count     = count_q;
    assign out_en    = out_en_q;
    assign in_en     = in_en_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: directed scenarios plus random traffic,
// compared each cycle against a transaction-level schedule model.
module tb_bus_transfer_sequencer;

    localparam int DEPTH = 4;
    localparam int NCODE = 25;

    logic               clk = 1'b0;
    logic               clr_n;
    logic               req_valid;
    logic               req_ready;
    logic [4:0]         req_src;
    logic [4:0]         req_dst;
    logic [NCODE-1:0]   out_en;
    logic [NCODE-1:0]   in_en;
    logic               busy;
    logic               err;
    logic [$clog2(DEPTH):0] count;
`ifdef BUS_XFER_HOLD_EN
    logic               hold = 1'b0;
`endif

    bus_transfer_sequencer #(.DEPTH(DEPTH), .NCODE(NCODE)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
`ifdef BUS_XFER_HOLD_EN
        .hold      (hold),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .out_en    (out_en),
        .in_en     (in_en),
        .busy      (busy),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Each accepted request becomes a record with the edge it was accepted on and the
    // edge it leaves the queue on. A legal transfer drives the bus for the two cycles
    // after its pop edge; an illegal one only occupies its pop edge.
    typedef struct {
        logic [4:0] src;
        logic [4:0] dst;
        int         acc;
        int         pop;
        bit         legal;
    } rec_t;

    rec_t  recs[$];
    int    n;          // rising edges since the last reset release
    int    free_edge;  // earliest edge on which the engine can take the next entry
    int    tests = 0;
    int    fails = 0;

    logic [31:0] exp_out, exp_in, exp_cnt;
    logic        exp_busy, exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, n, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] s, input logic [4:0] d);
        return (s <= 5'd24) && (d <= 5'd23) && (d != 5'd18) && (d != 5'd19);
    endfunction

    function automatic int model_count(input int e);
        int c = 0;
        foreach (recs[i]) if (recs[i].acc <= e && recs[i].pop > e) c++;
        return c;
    endfunction

    task automatic model_eval();
        exp_out  = '0;
        exp_in   = '0;
        exp_err  = 1'b0;
        exp_cnt  = 32'(model_count(n));
        exp_busy = (exp_cnt != 0);
        foreach (recs[i]) begin
            if (recs[i].legal && (recs[i].pop == n || recs[i].pop == n - 1)) begin
                exp_out  = 32'd1 << recs[i].src;
                exp_busy = 1'b1;
            end
            if (recs[i].legal && recs[i].pop == n - 1) exp_in = 32'd1 << recs[i].dst;
            if (!recs[i].legal && recs[i].pop <= n) exp_err = 1'b1;
        end
    endtask

    task automatic check_all();
        model_eval();
        check("out_en",    32'(out_en),    exp_out);
        check("in_en",     32'(in_en),     exp_in);
        check("busy",      32'(busy),      32'(exp_busy));
        check("err",       32'(err),       32'(exp_err));
        check("count",     32'(count),     exp_cnt);
        check("req_ready", 32'(req_ready), 32'(exp_cnt < DEPTH));
    endtask

    // Called just after a falling edge; drives one request slot and checks the result.
    task automatic cycle(input bit v, input logic [4:0] s, input logic [4:0] d);
        rec_t r;
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        if (v && model_count(n) < DEPTH) begin
            r.src   = s;
            r.dst   = d;
            r.acc   = n + 1;
            r.legal = is_legal(s, d);
            r.pop   = (r.acc + 1 > free_edge) ? r.acc + 1 : free_edge;
            free_edge = r.legal ? r.pop + 2 : r.pop + 1;
            recs.push_back(r);
        end
        @(posedge clk);
        n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 5'd0, 5'd0);
    endtask

    task automatic model_reset();
        recs.delete();
        free_edge = 0;
    endtask

    initial begin
        logic [4:0] s, d;
        bit found;
        clr_n     = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        n         = 0;
        model_reset();

        // Reset state, then release with no traffic.
        repeat (2) @(negedge clk);
        check_all();
        clr_n = 1'b1;
        idle(3);

        // Single transfer src=3 -> dst=7.
        cycle(1'b1, 5'd3, 5'd7);
        idle(4);

        // A burst longer than the FIFO, then let it drain back-to-back.
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'(i + 2), 5'(i));
        idle(14);

        // Illegal destination followed by a legal request; src==dst also legal.
        cycle(1'b1, 5'd20, 5'd24);
        cycle(1'b1, 5'd2, 5'd9);
        cycle(1'b1, 5'd31, 5'd1);
        cycle(1'b1, 5'd17, 5'd17);
        idle(8);

        // Random traffic, mostly legal codes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                s = 5'($urandom_range(0, 31));
                d = 5'($urandom_range(0, 31));
            end else begin
                s = 5'($urandom_range(0, 24));
                d = 5'($urandom_range(0, 21));
                if (d >= 5'd18) d = d + 5'd2;
            end
            cycle($urandom_range(0, 99) < 70, s, d);
        end
        idle(10);

        // Asynchronous reset while a transfer is in LATCH with more work queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'(10 + i), 5'(4 + i));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            model_eval();
            if (exp_in != 0) found = 1'b1;
            else cycle(1'b0, 5'd0, 5'd0);
        end
        check("latch_reached", 32'(found), 32'd1);
        req_valid = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_in_en",  32'(in_en),  32'd0);
        check("rst_count",  32'(count),  32'd0);
        #1 clr_n = 1'b1;
        model_reset();
        idle(3);
        cycle(1'b1, 5'd24, 5'd23);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
